// File: rtl/tug_of_war_field.sv
// Two-player tug-of-war: one lit position is pulled left/right by key presses;
// running off either end wins a round, WIN_SCORE rounds wins the match.
module tug_of_war_field #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3,
  parameter int WIN_SCORE  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L,
  input  logic                  R,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]    left_score,
  output logic [SCORE_W-1:0]    right_score,
  output logic                  left_win,
  output logic                  right_win,
  output logic                  match_over
);

  localparam int POS_W = (NUM_LIGHTS > 2) ? $clog2(NUM_LIGHTS) : 1;
  localparam logic [POS_W-1:0]      CTR        = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]      LEFT_END   = POS_W'(NUM_LIGHTS - 1);
  localparam logic [POS_W-1:0]      RIGHT_END  = '0;
  localparam logic [NUM_LIGHTS-1:0] CTR_ONEHOT = NUM_LIGHTS'(1) << CTR;
  localparam logic [SCORE_W-1:0]    WIN_M1     = SCORE_W'(WIN_SCORE - 1);

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    ROUND_END = 2'd1,
    MATCH_END = 2'd2
  } state_t;

  state_t                state_q;
  logic [POS_W-1:0]      pos_q;
  logic [NUM_LIGHTS-1:0] lights_q;
  logic [SCORE_W-1:0]    left_score_q;
  logic [SCORE_W-1:0]    right_score_q;
  logic                  left_win_q;
  logic                  right_win_q;
  logic                  match_over_q;
  logic                  l_prev_q;
  logic                  r_prev_q;

  logic lp;
  logic rp;

  // Previous-key registers reset high so a key held across reset is not a press.
  assign lp = L & ~l_prev_q;
  assign rp = R & ~r_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= PLAY;
      pos_q         <= CTR;
      lights_q      <= CTR_ONEHOT;
      left_score_q  <= '0;
      right_score_q <= '0;
      left_win_q    <= 1'b0;
      right_win_q   <= 1'b0;
      match_over_q  <= 1'b0;
      l_prev_q      <= 1'b1;
      r_prev_q      <= 1'b1;
    end else begin
      l_prev_q <= L;
      r_prev_q <= R;
      case (state_q)
        PLAY: begin
          if (lp && !rp) begin
            if (pos_q == LEFT_END) begin
              left_score_q <= left_score_q + 1'b1;
              left_win_q   <= 1'b1;
              right_win_q  <= 1'b0;
              lights_q     <= '0;
              if (left_score_q == WIN_M1) begin
                state_q      <= MATCH_END;
                match_over_q <= 1'b1;
              end else begin
                state_q <= ROUND_END;
              end
            end else begin
              pos_q    <= pos_q + 1'b1;
              lights_q <= lights_q << 1;
            end
          end else if (rp && !lp) begin
            if (pos_q == RIGHT_END) begin
              right_score_q <= right_score_q + 1'b1;
              right_win_q   <= 1'b1;
              left_win_q    <= 1'b0;
              lights_q      <= '0;
              if (right_score_q == WIN_M1) begin
                state_q      <= MATCH_END;
                match_over_q <= 1'b1;
              end else begin
                state_q <= ROUND_END;
              end
            end else begin
              pos_q    <= pos_q - 1'b1;
              lights_q <= lights_q >> 1;
            end
          end
        end
        ROUND_END: begin
          // The press that restarts play only re-centres; it never moves the light.
          if (lp || rp) begin
            left_win_q  <= 1'b0;
            right_win_q <= 1'b0;
            pos_q       <= CTR;
            lights_q    <= CTR_ONEHOT;
            state_q     <= PLAY;
          end
        end
        MATCH_END: begin
          state_q <= MATCH_END;
        end
        default: begin
          state_q  <= PLAY;
          pos_q    <= CTR;
          lights_q <= CTR_ONEHOT;
        end
      endcase
    end
  end

  assign lights      = lights_q;
  assign left_score  = left_score_q;
  assign right_score = right_score_q;
  assign left_win    = left_win_q;
  assign right_win   = right_win_q;
  assign match_over  = match_over_q;

endmodule

// File: tb/tb_tug_of_war_field.sv
// Scoreboard bench for tug_of_war_field (5 lights, first to 2 rounds).
// Driver feeds keys and a rule-level model; monitor pops expectations each cycle.
module tb_tug_of_war_field;
  localparam int NL = 5;
  localparam int SW = 3;
  localparam int WS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          L = 1'b0;
  logic          R = 1'b0;
  logic [NL-1:0] lights;
  logic [SW-1:0] left_score, right_score;
  logic          left_win, right_win, match_over;

  tug_of_war_field #(.NUM_LIGHTS(NL), .SCORE_W(SW), .WIN_SCORE(WS)) dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .lights(lights),
    .left_score(left_score), .right_score(right_score),
    .left_win(left_win), .right_win(right_win), .match_over(match_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NL-1:0] lights;
    logic [SW-1:0] ls;
    logic [SW-1:0] rs;
    logic          lw;
    logic          rw;
    logic          mo;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: game phase 0 = playing, 1 = round won, 2 = match won.
  int m_phase, m_pos, m_ls, m_rs;
  bit m_lw, m_rw, m_mo, m_pl, m_pr;

  task automatic m_reset();
    m_phase = 0; m_pos = (NL - 1) / 2; m_ls = 0; m_rs = 0;
    m_lw = 0; m_rw = 0; m_mo = 0; m_pl = 1; m_pr = 1;
  endtask

  function automatic out_t m_out();
    out_t o;
    o.lights = (m_phase == 0) ? NL'(1 << m_pos) : '0;
    o.ls = SW'(m_ls); o.rs = SW'(m_rs);
    o.lw = m_lw; o.rw = m_rw; o.mo = m_mo;
    return o;
  endfunction

  task automatic m_step(input bit l, input bit r);
    bit lpress, rpress;
    lpress = l && !m_pl;
    rpress = r && !m_pr;
    m_pl = l; m_pr = r;
    if (m_phase == 0) begin
      if (lpress && !rpress) begin
        if (m_pos == NL - 1) begin
          m_ls++; m_lw = 1; m_rw = 0;
          m_phase = (m_ls == WS) ? 2 : 1;
          m_mo = (m_ls == WS);
        end else m_pos++;
      end else if (rpress && !lpress) begin
        if (m_pos == 0) begin
          m_rs++; m_rw = 1; m_lw = 0;
          m_phase = (m_rs == WS) ? 2 : 1;
          m_mo = (m_rs == WS);
        end else m_pos--;
      end
    end else if (m_phase == 1) begin
      if (lpress || rpress) begin
        m_lw = 0; m_rw = 0; m_pos = (NL - 1) / 2; m_phase = 0;
      end
    end
  endtask

  function automatic out_t dut_out();
    return {lights, left_score, right_score, left_win, right_win, match_over};
  endfunction

  task automatic compare(input string name, input out_t got, input out_t want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got lights=%b ls=%0d rs=%0d lw=%b rw=%b mo=%b, expected lights=%b ls=%0d rs=%0d lw=%b rw=%b mo=%b",
                  name, got.lights, got.ls, got.rs, got.lw, got.rw, got.mo,
                  want.lights, want.ls, want.rs, want.lw, want.rw, want.mo);
  endtask

  task automatic drive(input bit l, input bit r);
    @(negedge clk);
    L = l; R = r;
    m_step(l, r);
    exp_q.push_back(m_out());
  endtask

  // Absolute check of outputs just after the edge that consumed the last drive.
  task automatic check_const(input string name, input out_t want);
    @(posedge clk); #2;
    compare(name, dut_out(), want);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic apply_reset(input string name);
    out_t rst_val;
    rst_val = '{lights: 5'b00100, ls: 0, rs: 0, lw: 0, rw: 0, mo: 0};
    @(negedge clk); #3;
    reset = 1'b1;
    #1;
    compare(name, dut_out(), rst_val);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    m_step(L, R);
    exp_q.push_back(m_out());
  endtask

  // Monitor: one transaction per clock edge for which stimulus was issued.
  initial begin
    out_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("cycle", dut_out(), e);
        checks++;
        if (!(left_win && right_win)) passes++;
        else $display("FAIL win_exclusive: got lw=%b rw=%b, expected not both high", left_win, right_win);
      end
    end
  end

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    compare("reset_hold", dut_out(), '{lights: 5'b00100, ls: 0, rs: 0, lw: 0, rw: 0, mo: 0});
    @(negedge clk);
    reset = 1'b0;
    m_step(0, 0); exp_q.push_back(m_out());

    // L held ten cycles: one move only, then a second press.
    for (int i = 0; i < 10; i++) drive(1, 0);
    drive(0, 0);
    drive(1, 0);
    check_const("second_L", '{lights: 5'b10000, ls: 0, rs: 0, lw: 0, rw: 0, mo: 0});

    // Simultaneous presses cancel; lone R then moves right.
    apply_reset("async_reset_edge");
    drive(0, 0);
    drive(1, 1);
    check_const("simultaneous", '{lights: 5'b00100, ls: 0, rs: 0, lw: 0, rw: 0, mo: 0});
    drive(0, 0);
    drive(0, 1);
    check_const("R_after_both", '{lights: 5'b00010, ls: 0, rs: 0, lw: 0, rw: 0, mo: 0});

    // Right wins two rounds -> match over and frozen.
    apply_reset("async_reset_play");
    drive(0, 0);
    for (int i = 0; i < 3; i++) begin drive(0, 1); drive(0, 0); end
    check_const("right_round", '{lights: 5'b00000, ls: 0, rs: 1, lw: 0, rw: 1, mo: 0});
    drive(1, 0);
    check_const("restart", '{lights: 5'b00100, ls: 0, rs: 1, lw: 0, rw: 0, mo: 0});
    drive(0, 0);
    for (int i = 0; i < 3; i++) begin drive(0, 1); drive(0, 0); end
    check_const("match_end", '{lights: 5'b00000, ls: 0, rs: 2, lw: 0, rw: 1, mo: 1});
    for (int i = 0; i < 4; i++) begin drive(1, 0); drive(0, 1); drive(0, 0); end
    check_const("frozen", '{lights: 5'b00000, ls: 0, rs: 2, lw: 0, rw: 1, mo: 1});

    // Mid-round async reset at 01000, with L held through release.
    apply_reset("async_reset_match");
    drive(0, 0);
    drive(1, 0);
    check_const("at_01000", '{lights: 5'b01000, ls: 0, rs: 0, lw: 0, rw: 0, mo: 0});
    apply_reset("async_reset_mid");
    drive(1, 0);
    drive(1, 0);
    check_const("held_through_reset", '{lights: 5'b00100, ls: 0, rs: 0, lw: 0, rw: 0, mo: 0});

    // Randomized play, biased so rounds and matches complete, with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) apply_reset("async_reset_rand");
      else drive($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40);
    end
    drive(0, 0);
    @(posedge clk); #3;

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end
endmodule
